// File: rtl/cmp_event_tracker.sv
// Debounced relation tracker for the one-hot G/L/E comparator stream, with
// saturating class counters and an illegal-encoding pulse. Optional latched
// interrupt enabled by defining CMP_TRACK_IRQ_EN.
module cmp_event_tracker #(
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             G,
    input  logic             L,
    input  logic             E,
    input  logic             clr,
    input  logic             irq_ack,
    output logic [1:0]       state,
    output logic             changed,
    output logic             err,
    output logic [CNT_W-1:0] cnt_g,
    output logic [CNT_W-1:0] cnt_l,
    output logic [CNT_W-1:0] cnt_e,
    output logic             irq
);

    localparam int unsigned      RUN_W   = 4;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ABOVE = 2'b01,
        ST_BELOW = 2'b10,
        ST_EQUAL = 2'b11
    } state_e;

    state_e           state_q, state_d;
    state_e           cand_q, cand_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] cnt_g_q, cnt_g_d;
    logic [CNT_W-1:0] cnt_l_q, cnt_l_d;
    logic [CNT_W-1:0] cnt_e_q, cnt_e_d;
    logic             changed_q, changed_d;
    logic             err_q, err_d;
    logic             irq_q, irq_d;

    logic             legal_c;
    logic             illegal_c;
    state_e           class_c;

    // Classify the incoming sample
    always_comb begin
        legal_c   = in_valid && $onehot({G, L, E});
        illegal_c = in_valid && !$onehot({G, L, E});
        if (G) begin
            class_c = ST_ABOVE;
        end else if (L) begin
            class_c = ST_BELOW;
        end else begin
            class_c = ST_EQUAL;
        end
    end

    // Next-state: clear, illegal sample, or legal sample with debounce
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        run_d     = run_q;
        cnt_g_d   = cnt_g_q;
        cnt_l_d   = cnt_l_q;
        cnt_e_d   = cnt_e_q;
        changed_d = 1'b0;
        err_d     = 1'b0;

        if (clr) begin
            state_d = ST_IDLE;
            cand_d  = ST_IDLE;
            run_d   = '0;
            cnt_g_d = '0;
            cnt_l_d = '0;
            cnt_e_d = '0;
        end else if (illegal_c) begin
            err_d = 1'b1;
            run_d = '0;
        end else if (legal_c) begin
            case (class_c)
                ST_ABOVE: cnt_g_d = (cnt_g_q == CNT_MAX) ? cnt_g_q : cnt_g_q + CNT_W'(1);
                ST_BELOW: cnt_l_d = (cnt_l_q == CNT_MAX) ? cnt_l_q : cnt_l_q + CNT_W'(1);
                default:  cnt_e_d = (cnt_e_q == CNT_MAX) ? cnt_e_q : cnt_e_q + CNT_W'(1);
            endcase

            if (class_c == cand_q) begin
                run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
            end else begin
                cand_d = class_c;
                run_d  = RUN_W'(1);
            end

            // Commit only on reaching the threshold with a new relation
            if ((run_d == RUN_MAX) && (cand_d != state_q)) begin
                state_d   = cand_d;
                changed_d = 1'b1;
            end
        end
    end

`ifdef CMP_TRACK_IRQ_EN
    // Latched interrupt; a new change beats a same-cycle acknowledge
    always_comb begin
        irq_d = irq_q;
        if (changed_d) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end
    end
`else
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack;

    always_comb begin
        irq_d = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cand_q    <= ST_IDLE;
            run_q     <= '0;
            cnt_g_q   <= '0;
            cnt_l_q   <= '0;
            cnt_e_q   <= '0;
            changed_q <= 1'b0;
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            run_q     <= run_d;
            cnt_g_q   <= cnt_g_d;
            cnt_l_q   <= cnt_l_d;
            cnt_e_q   <= cnt_e_d;
            changed_q <= changed_d;
            err_q     <= err_d;
            irq_q     <= irq_d;
        end
    end

    assign state   = state_q;
    assign changed = changed_q;
    assign err     = err_q;
    assign cnt_g   = cnt_g_q;
    assign cnt_l   = cnt_l_q;
    assign cnt_e   = cnt_e_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_cmp_event_tracker.sv
// Directed bench for cmp_event_tracker (DEBOUNCE=3, CNT_W=4); the irq checks
// follow CMP_TRACK_IRQ_EN the same way the design does.
module tb_cmp_event_tracker;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       G, L, E;
    logic       clr;
    logic       irq_ack;
    logic [1:0] state;
    logic       changed;
    logic       err;
    logic [3:0] cnt_g, cnt_l, cnt_e;
    logic       irq;

    int errors = 0;
    int checks = 0;

    cmp_event_tracker #(.DEBOUNCE(3), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .G        (G),
        .L        (L),
        .E        (E),
        .clr      (clr),
        .irq_ack  (irq_ack),
        .state    (state),
        .changed  (changed),
        .err      (err),
        .cnt_g    (cnt_g),
        .cnt_l    (cnt_l),
        .cnt_e    (cnt_e),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One edge with the given inputs; outputs sampled 1 time unit later
    task automatic step(input logic v, input logic [2:0] gle, input logic c, input logic ack);
        in_valid = v;
        {G, L, E} = gle;
        clr = c;
        irq_ack = ack;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        {G, L, E} = 3'b000;
        clr = 1'b0;
        irq_ack = 1'b0;
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0;
        in_valid = 1'b0;
        {G, L, E} = 3'b000;
        clr = 1'b0;
        irq_ack = 1'b0;

        // Reset state
        #12;
        check("rst_state", state, 0);
        check("rst_changed", changed, 0);
        check("rst_err", err, 0);
        check("rst_cnts", {cnt_g, cnt_l, cnt_e}, 0);
        check("rst_irq", irq, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // G,G,G: state changes after the third edge only
        step(1, 3'b100, 0, 0);
        check("ggg_e1_state", state, 0);
        check("ggg_e1_changed", changed, 0);
        step(1, 3'b100, 0, 0);
        check("ggg_e2_state", state, 0);
        step(1, 3'b100, 0, 0);
        check("ggg_e3_state", state, 1);
        check("ggg_e3_changed", changed, 1);
        check("ggg_cnt_g", cnt_g, 3);
`ifdef CMP_TRACK_IRQ_EN
        check("irq_set", irq, 1);
`else
        check("irq_tied", irq, 0);
`endif
        step(0, 3'b000, 0, 0);
        check("ggg_changed_drop", changed, 0);
        check("ggg_state_hold", state, 1);
`ifdef CMP_TRACK_IRQ_EN
        check("irq_held", irq, 1);
        step(0, 3'b000, 0, 1);
        check("irq_ack_clr", irq, 0);
`endif

        // clr then G,G,L,G,G,G: one pulse, only after the sixth sample
        step(0, 3'b000, 1, 0);
        check("clr_state", state, 0);
        check("clr_cnts", {cnt_g, cnt_l, cnt_e}, 0);
        pulses = 0;
        step(1, 3'b100, 0, 0); pulses += int'(changed);
        step(1, 3'b100, 0, 0); pulses += int'(changed);
        step(1, 3'b010, 0, 0); pulses += int'(changed);
        step(1, 3'b100, 0, 0); pulses += int'(changed);
        step(1, 3'b100, 0, 0); pulses += int'(changed);
        check("gglggg_s5_state", state, 0);
        step(1, 3'b100, 0, 0); pulses += int'(changed);
        check("gglggg_state", state, 1);
        check("gglggg_pulses", pulses, 1);
        check("gglggg_cnt_g", cnt_g, 5);
        check("gglggg_cnt_l", cnt_l, 1);

        // Illegal 110 breaks the run: G,G,<110>,G,G keeps IDLE, third G commits
        step(0, 3'b000, 1, 0);
        step(1, 3'b100, 0, 0);
        step(1, 3'b100, 0, 0);
        step(1, 3'b110, 0, 0);
        check("ill110_err", err, 1);
        check("ill110_state", state, 0);
        check("ill110_cnts", {cnt_g, cnt_l, cnt_e}, 12'h200);
        step(1, 3'b100, 0, 0);
        check("ill110_err_drop", err, 0);
        step(1, 3'b100, 0, 0);
        check("ill110_gg_state", state, 0);
        step(1, 3'b100, 0, 0);
        check("ill110_ggg_state", state, 1);
        check("ill110_ggg_changed", changed, 1);
        check("ill110_cnt_g", cnt_g, 5);

        // Illegal 000: L,L,<000>,L,L stays ABOVE, third L moves to BELOW
        step(1, 3'b010, 0, 0);
        step(1, 3'b010, 0, 0);
        step(1, 3'b000, 0, 0);
        check("ill000_err", err, 1);
        check("ill000_cnt_l", cnt_l, 2);
        step(1, 3'b010, 0, 0);
        step(1, 3'b010, 0, 0);
        check("ill000_ll_state", state, 1);
        step(1, 3'b010, 0, 0);
        check("ill000_state", state, 2);
        check("ill000_changed", changed, 1);
        check("ill000_cnt_l", cnt_l, 5);

        // 20 E samples: counter saturates at 15, single pulse
        step(0, 3'b000, 1, 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 3'b001, 0, 0);
            pulses += int'(changed);
        end
        check("e20_cnt_e", cnt_e, 15);
        check("e20_state", state, 3);
        check("e20_pulses", pulses, 1);

        // clr together with a valid L after reaching ABOVE
        step(0, 3'b000, 1, 0);
        step(1, 3'b100, 0, 0);
        step(1, 3'b100, 0, 0);
        step(1, 3'b100, 0, 0);
        check("clrl_pre_state", state, 1);
        step(1, 3'b010, 1, 0);
        check("clrl_state", state, 0);
        check("clrl_cnts", {cnt_g, cnt_l, cnt_e}, 0);
        check("clrl_changed", changed, 0);
`ifdef CMP_TRACK_IRQ_EN
        check("clrl_irq_kept", irq, 1);
        // Set and acknowledge on the same edge: set wins
        step(0, 3'b000, 0, 1);
        step(1, 3'b001, 0, 0);
        step(1, 3'b001, 0, 0);
        step(1, 3'b001, 0, 1);
        check("irq_set_vs_ack", irq, 1);
`endif

        // Asynchronous reset mid-cycle
        step(0, 3'b000, 1, 0);
        step(1, 3'b010, 0, 0);
        step(1, 3'b010, 0, 0);
        step(1, 3'b010, 0, 0);
        check("arst_pre_state", state, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_changed", changed, 0);
        check("arst_cnts", {cnt_g, cnt_l, cnt_e}, 0);
        check("arst_irq", irq, 0);
        #2;
        rst_n = 1'b1;
        step(0, 3'b000, 0, 0);
        check("arst_post_state", state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmp_event_tracker.md
Name: cmp_event_tracker

Overview:
- Sequential stage directly downstream of the 4-bit magnitude comparator. Consumes its one-hot G/L/E result stream.
- Debounces the stream into a stable relation state: ABOVE, BELOW or EQUAL.
- Keeps saturating per-class occurrence counters and flags illegal (non-one-hot) flag encodings.
- Feeds status/interrupt logic.

Parameters:
- DEBOUNCE, 3: consecutive identical valid samples required to change state; legal range 1..15.
- CNT_W, 4: width of each occurrence counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  G/L/E sample valid this cycle.
- G  in  1  comparator a>b flag.
- L  in  1  comparator a<b flag.
- E  in  1  comparator a==b flag.
- clr  in  1  synchronous clear of tracker.
- irq_ack  in  1  interrupt acknowledge (used only with the optional feature).
- state  out  2  stable relation: 00 IDLE, 01 ABOVE, 10 BELOW, 11 EQUAL.
- changed  out  1  one-cycle pulse when state changes.
- err  out  1  one-cycle pulse on an illegal flag sample.
- cnt_g  out  CNT_W  saturating count of valid G samples.
- cnt_l  out  CNT_W  saturating count of valid L samples.
- cnt_e  out  CNT_W  saturating count of valid E samples.
- irq  out  1  latched state-change interrupt.

Behaviour:
- Reset
  - Asynchronous: asserting rst_n low forces every output and internal register to 0 immediately, with no clock edge required.
  - Reset values: state=00, changed=0, err=0, cnt_*=0, irq=0, run=0, cand=00.
  - Release is synchronous to the next clk edge.
- All outputs are registered. A sample on edge N affects outputs from the cycle after edge N, i.e. 1-cycle latency.
- Sample legality
  - A sample is legal when in_valid=1 and exactly one of {G,L,E} is 1.
  - It is classified as ABOVE (G), BELOW (L) or EQUAL (E).
- Illegal sample (in_valid=1, {G,L,E} not one-hot, including 000):
  - err=1 for one cycle.
  - run<=0; counters and state unchanged.
- in_valid=0: nothing changes; changed and err return to 0.
- Legal sample, counters:
  - The matching cnt_* increments, saturating at 2^CNT_W-1 (no wrap).
- Legal sample, debounce:
  - Class == cand: run increments, saturating at DEBOUNCE.
  - Otherwise: cand<=class, run<=1.
- State change:
  - When the updated run equals DEBOUNCE and cand != state: state<=cand and changed=1 for exactly one cycle.
  - Further identical samples do not re-pulse changed.
  - With DEBOUNCE=1, state follows each legal sample with no filtering.
- FSM: IDLE -> {ABOVE, BELOW, EQUAL}, and any non-IDLE state -> any other non-IDLE state, all via the debounce rule. IDLE is re-entered only by reset or clr.
- clr=1
  - Next edge: state=00, counters=0, run=0, cand=00, changed=0, err=0.
  - irq is not affected.
  - clr has priority over a simultaneous in_valid; that sample is dropped.

Optional Feature:
- Macro: CMP_TRACK_IRQ_EN.
- Defined:
  - irq is set on the same edge that produces changed.
  - irq stays set until an edge with irq_ack=1 clears it.
  - If set and ack occur on the same edge, set wins and irq stays 1.
- Undefined: irq is tied to 0 and irq_ack is ignored. Ports remain present.

Test Plan:
- Defaults, after reset: G,G,G with in_valid=1 on consecutive edges -> state 00 after edges 1-2; state=01 and changed=1 for one cycle after edge 3; cnt_g=3.
- G,G,L,G,G,G -> state changes only after the 6th sample, to 01; cnt_g=5, cnt_l=1; exactly one changed pulse.
- Sample {G,L,E}=110, in_valid=1 -> err pulse; counters and state unchanged; next G,G,G is still required to reach 01. Repeat with {G,L,E}=000 -> same response.
- 20 consecutive E samples with CNT_W=4 -> cnt_e=15 (saturated), state=11, a single changed pulse.
- clr=1 together with a valid L after reaching state 01 -> state=00, all cnt_*=0; the L sample is not counted.
- Drive rst_n low mid-run between clock edges -> all outputs 0 before the next edge. With CMP_TRACK_IRQ_EN defined: irq=1 after a state change, held until irq_ack; set and ack on the same edge keep irq=1.
